// File: rtl/btn_toggle_bank.sv
// Bank of N independent debounced push-button channels: debounced level, press pulse and press toggle.
// Define BTN_BANK_SYNC_EN to put a two-flop synchroniser in front of each debouncer (needed for real pins).
module btn_toggle_bank #(
  parameter int N        = 4,
  parameter int DEBOUNCE = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] btn,
  input  logic [N-1:0] clr,
  output logic [N-1:0] stable,
  output logic [N-1:0] press,
  output logic [N-1:0] q
);

  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

  logic [N-1:0] s;

`ifdef BTN_BANK_SYNC_EN
  logic [N-1:0] sync1;
  logic [N-1:0] sync2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

  assign s = sync2;
`else
  assign s = btn;
`endif

  for (genvar i = 0; i < N; i++) begin : g_chan
    logic [CW-1:0] cnt;
    logic          stableR;
    logic          pressR;
    logic          qR;
    logic          differ;
    logic          accept;

    assign differ = s[i] ^ stableR;
    assign accept = differ && (cnt == CNT_LAST);

    // Counter restarts on any sample matching the accepted level, so only an unbroken run is accepted.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        cnt     <= '0;
        stableR <= 1'b0;
        pressR  <= 1'b0;
        qR      <= 1'b0;
      end else begin
        pressR <= accept & s[i];
        if (!differ || accept)
          cnt <= '0;
        else
          cnt <= cnt + CW'(1);
        if (accept)
          stableR <= s[i];
        if (clr[i])
          qR <= 1'b0;
        else if (accept && s[i])
          qR <= ~qR;
      end
    end

    assign stable[i] = stableR;
    assign press[i]  = pressR;
    assign q[i]      = qR;
  end

endmodule
